branch_pc_unit: RTL and testbench

Owns the program counter and resolves the next fetch address for the MIPS pipeline. It consumes the word-aligned branch offset produced by the immediate left-shift stage (sign-extended imm << 2), adds it to the branch's PC+4 to form the branch target, and also forms J-type targets. A redirect that arrives during a stall is held in a single-entry buffer until it can be applied. It generates the fetch-flush strobe and a taken-branch count.

---
 rtl/branch_pc_unit.sv | 120 ++++++++++++
 tb/tb_branch_pc_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   Owns the MIPS fetch program counter and picks the next fetch address.
//   Branch targets are br_pc4 + imm_shifted (offset already word-aligned by
//   the shift stage). Jump targets splice jmp_index into the upper PC nibble.
//   A redirect that shows up while the pipe is stalled is parked in a
//   single-entry buffer and applied on the first unstalled cycle.
//
// Ports
//   Clk              : system clock, rising edge
//   Rst              : synchronous active-high reset
//   stall            : hazard stall, PC holds while high
//   br_valid         : branch resolved in ID this cycle
//   br_taken         : branch condition true (qualified by br_valid)
//   br_pc4           : PC+4 of the branch/jump in ID
//   imm_shifted      : branch offset, already shifted left by 2
//   jmp_valid        : J/JAL in ID this cycle
//   jmp_index        : instr[25:0] of the jump
//   pc_out           : current fetch PC (registered)
//   pc4_out          : pc_out + 4 (combinational)
//   flush            : kill the IF/ID instruction this cycle
//   redirect_pending : a buffered redirect is waiting for an unstalled cycle
//   taken_cnt        : saturating count of redirects loaded into the PC

module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [31:0]      br_pc4,
  input  logic [31:0]      imm_shifted,
  input  logic             jmp_valid,
  input  logic [25:0]      jmp_index,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc4_out,
  output logic             flush,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [31:0]      pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        cur_req;
  logic [31:0] cur_tgt;
  logic        load_redirect;

  // Target arithmetic wraps modulo 2^32; low bits are passed through untouched.
  assign br_target = br_pc4 + imm_shifted;
  assign j_target  = {br_pc4[31:28], jmp_index, 2'b00};

  // A jump in ID outranks a branch resolving in the same cycle.
  assign cur_req = jmp_valid | (br_valid & br_taken);
  assign cur_tgt = jmp_valid ? j_target : br_target;

  // A redirect is only loaded on an unstalled, non-reset cycle, either the
  // live one or the parked one.
  assign load_redirect = ~Rst & ~stall & (cur_req | pend_valid_q);

  // Next-state selection for PC, pending buffer and counter. Reset is handled
  // in the register process so it overrides everything here.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    cnt_d        = cnt_q;

    if (stall) begin
      // Newest request wins the buffer; older parked target is overwritten.
      if (cur_req) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = cur_tgt;
      end
    end else begin
      pend_valid_d = 1'b0;
      if (cur_req) begin
        pc_d = cur_tgt;
      end else if (pend_valid_q) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end

    if (load_redirect && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; reset discards any parked redirect.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= 32'h0000_0000;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pc_out           = pc_q;
  assign pc4_out          = pc_q + 32'd4;
  assign flush            = load_redirect;
  assign redirect_pending = pend_valid_q;
  assign taken_cnt        = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit
//   Scoreboard bench for branch_pc_unit built with a 2-bit counter so that
//   saturation is reachable. Each stimulus cycle runs a reference model,
//   pushes the expected post-edge state onto a queue, and after the edge the
//   entry is popped and compared against the DUT.

module tb_branch_pc_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          CntW    = 2;

  logic            Clk;
  logic            Rst;
  logic            stall;
  logic            br_valid;
  logic            br_taken;
  logic [31:0]     br_pc4;
  logic [31:0]     imm_shifted;
  logic            jmp_valid;
  logic [25:0]     jmp_index;
  logic [31:0]     pc_out;
  logic [31:0]     pc4_out;
  logic            flush;
  logic            redirect_pending;
  logic [CntW-1:0] taken_cnt;

  branch_pc_unit #(
    .RESET_PC (ResetPc),
    .CNT_W    (CntW)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_taken         (br_taken),
    .br_pc4           (br_pc4),
    .imm_shifted      (imm_shifted),
    .jmp_valid        (jmp_valid),
    .jmp_index        (jmp_index),
    .pc_out           (pc_out),
    .pc4_out          (pc4_out),
    .flush            (flush),
    .redirect_pending (redirect_pending),
    .taken_cnt        (taken_cnt)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic        flush;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        pend;
    logic [31:0] cnt;
  } expEntry_t;

  expEntry_t expQueue[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic [31:0]     mPc;
  logic            mPend;
  logic [31:0]     mPendTgt;
  logic [CntW-1:0] mCnt;

  // Values sampled from the DUT during the driven cycle, before the edge.
  logic        obsFlush;
  logic [31:0] obsPc4;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, model it, push the expectation and sample the
  // combinational outputs of this cycle.
  task automatic applyStimulus(input string tag, input logic rst, input logic stl,
                               input logic bv, input logic bt, input logic [31:0] pc4,
                               input logic [31:0] imm, input logic jv,
                               input logic [25:0] idx);
    expEntry_t   e;
    logic        req;
    logic [31:0] tgt;
    Rst = rst; stall = stl; br_valid = bv; br_taken = bt;
    br_pc4 = pc4; imm_shifted = imm; jmp_valid = jv; jmp_index = idx;

    req = jv | (bv & bt);
    tgt = jv ? {pc4[31:28], idx, 2'b00} : (pc4 + imm);

    e.tag   = tag;
    e.pc4   = mPc + 32'd4;
    e.flush = 1'b0;
    if (rst) begin
      mPc = ResetPc; mPend = 1'b0; mPendTgt = 32'h0; mCnt = '0;
    end else if (stl) begin
      if (req) begin
        mPend = 1'b1; mPendTgt = tgt;
      end
    end else begin
      if (req) begin
        e.flush = 1'b1; mPc = tgt;
      end else if (mPend) begin
        e.flush = 1'b1; mPc = mPendTgt;
      end else begin
        mPc = mPc + 32'd4;
      end
      mPend = 1'b0;
      if (e.flush && mCnt != 2'b11) mCnt = mCnt + 2'b01;
    end
    e.pc   = mPc;
    e.pend = mPend;
    e.cnt  = {30'b0, mCnt};
    expQueue.push_back(e);

    #2;
    obsFlush = flush;
    obsPc4   = pc4_out;
  endtask

  // Wait for the edge that consumes the stimulus, then pop and compare.
  task automatic collectResult();
    expEntry_t e;
    @(posedge Clk);
    #1;
    if (expQueue.size() == 0) begin
      checkOutput("queue_empty", 32'd0, 32'd1);
    end else begin
      e = expQueue.pop_front();
      checkOutput({e.tag, ".flush"}, {31'b0, obsFlush}, {31'b0, e.flush});
      checkOutput({e.tag, ".pc4"}, obsPc4, e.pc4);
      checkOutput({e.tag, ".pc"}, pc_out, e.pc);
      checkOutput({e.tag, ".pend"}, {31'b0, redirect_pending}, {31'b0, e.pend});
      checkOutput({e.tag, ".cnt"}, {30'b0, taken_cnt}, e.cnt);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic stl,
                      input logic bv, input logic bt, input logic [31:0] pc4,
                      input logic [31:0] imm, input logic jv, input logic [25:0] idx);
    applyStimulus(tag, rst, stl, bv, bt, pc4, imm, jv, idx);
    collectResult();
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
  endtask

  initial begin
    // Bring-up reset outside the scoreboard so the model starts from known state.
    Rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_pc4 = 32'h0; imm_shifted = 32'h0; jmp_valid = 1'b0; jmp_index = 26'h0;
    @(posedge Clk);
    #1;
    mPc = ResetPc; mPend = 1'b0; mPendTgt = 32'h0; mCnt = '0;

    // Reset then sequential run.
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
    for (int i = 0; i < 4; i++) idle("seq");

    // Backward taken branch, then the same inputs not taken.
    step("br_back", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFF0, 1'b0, 26'h0);
    step("br_nt", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFF0, 1'b0, 26'h0);

    // Jump and taken branch together: jump wins.
    step("collide", 1'b0, 1'b0, 1'b1, 1'b1, 32'h4000_0008, 32'h0000_0020, 1'b1, 26'h000_0100);

    // Redirect captured during a three-cycle stall, applied on release.
    step("stall1", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00F0, 32'h0000_0010, 1'b0, 26'h0);
    step("stall2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
    step("stall3", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
    idle("release");
    idle("after_rel");

    // Target wrap past 2^32.
    step("wrap", 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 26'h0);

    // Reset with a redirect pending and live redirect inputs: all discarded.
    step("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0100, 1'b0, 26'h0);
    step("rst_pend", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h0, 1'b1, 26'h3FF_FFFF);
    idle("post_rst");

    // Counter saturation at 3 with five back-to-back taken branches.
    for (int i = 0; i < 5; i++)
      step("sat", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0010 << i, 1'b0, 26'h0);

    // Newer stalled request overwrites an older parked one.
    step("ovw_a", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0040, 1'b0, 26'h0);
    step("ovw_b", 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 26'h000_1234);
    idle("ovw_rel");

    // A live request on release beats the parked one.
    step("live_a", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0004, 1'b0, 26'h0);
    step("live_b", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0008, 1'b0, 26'h0);
    idle("live_c");

    // Short randomised run against the model.
    for (int i = 0; i < 60; i++)
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
           1'($urandom), 1'($urandom), $urandom, $urandom, ($urandom_range(0, 3) == 0),
           26'($urandom));

    if (expQueue.size() != 0)
      checkOutput("queue_leftover", expQueue.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
